// File: rtl/rx_frame_if.sv
// -----------------------------------------------------------------------------
// rx_frame_if
// Word handshake between the receive controller and its downstream consumer.
//   Frame_Data  : received word, held stable while Frame_Valid is high
//   Frame_Valid : Frame_Data holds a word not yet taken
//   Frame_Ready : consumer accepts the word when high together with Frame_Valid
// Modports: master (controller side), slave (consumer side).
// -----------------------------------------------------------------------------
interface rx_frame_if #(
    parameter int DATA_BITS = 8
) ();

    logic [DATA_BITS-1:0] Frame_Data;
    logic                 Frame_Valid;
    logic                 Frame_Ready;

    modport master (
        output Frame_Data,
        output Frame_Valid,
        input  Frame_Ready
    );

    modport slave (
        input  Frame_Data,
        input  Frame_Valid,
        output Frame_Ready
    );

endinterface

// File: rtl/rx_frame_controller.sv
// -----------------------------------------------------------------------------
// rx_frame_controller
// Sequencing controller for the single-bit receive stage. Arms the stage via
// Rx_Enable/Rx_Disable, finds the start bit, times bit centres with an
// oversampling counter, deserializes LSB-first frames and offers each good
// word on the rx_frame_if valid/ready handshake.
//
// Ports:
//   clk         : system clock
//   Reset       : asynchronous, active-low reset
//   Start       : arm the receiver (level or pulse)
//   Abort       : disarm and return to IDLE (wins over Start)
//   Rx_Bit      : serial bit from the receive stage
//   Rx_Enable   : receive stage enable (high in every state but IDLE)
//   Rx_Disable  : receive stage disable (high only in IDLE)
//   Busy        : a frame is being received
//   Framing_Err : 1-cycle pulse, stop bit sampled as 0
//   Overrun     : 1-cycle pulse, a completed word was dropped
//   Parity_Err  : 1-cycle pulse, parity mismatch (always 0 without the macro)
//   frame       : rx_frame_if.master word handshake
//
// Build option: define RX_PARITY_CHECK_EN to insert a PARITY bit time after
// the data bits; even parity over data plus parity bit is required.
// -----------------------------------------------------------------------------
module rx_frame_controller #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       Start,
    input  logic       Abort,
    input  logic       Rx_Bit,
    output logic       Rx_Enable,
    output logic       Rx_Disable,
    output logic       Busy,
    output logic       Framing_Err,
    output logic       Overrun,
    output logic       Parity_Err,
    rx_frame_if.master frame
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WAIT_START = 3'd1,
        S_START_CHK  = 3'd2,
        S_DATA       = 3'd3,
        S_PARITY     = 3'd4,
        S_STOP       = 3'd5
    } state_t;

    state_t               state_r;
    state_t               state_next_s;
    logic [CNT_W-1:0]     cnt_r;
    logic [CNT_W-1:0]     cnt_next_s;
    logic [IDX_W-1:0]     idx_r;
    logic [IDX_W-1:0]     idx_next_s;
    logic [DATA_BITS-1:0] shift_r;
    logic                 sample_data_s;
    logic                 sample_stop_s;
    logic                 commit_s;
    logic                 busy_next_s;

`ifdef RX_PARITY_CHECK_EN
    logic                 sample_par_s;
    logic                 par_bad_r;

    // Returns 1 when data plus parity bit carry an odd number of ones.
    function automatic logic parity_odd(input logic [DATA_BITS-1:0] data,
                                        input logic                 par);
        return ^{data, par};
    endfunction
`endif

    // State, oversampling counter and bit index registers.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_r <= S_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            idx_r   <= {IDX_W{1'b0}};
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            idx_r   <= idx_next_s;
        end
    end

    // Next-state logic and the bit-sample strobes.
    always_comb begin
        state_next_s  = state_r;
        cnt_next_s    = cnt_r + CNT_W'(1);
        idx_next_s    = idx_r;
        sample_data_s = 1'b0;
        sample_stop_s = 1'b0;
`ifdef RX_PARITY_CHECK_EN
        sample_par_s  = 1'b0;
`endif
        if (Abort) begin
            state_next_s = S_IDLE;
            cnt_next_s   = {CNT_W{1'b0}};
            idx_next_s   = {IDX_W{1'b0}};
        end else begin
            case (state_r)
                S_IDLE: begin
                    cnt_next_s = {CNT_W{1'b0}};
                    if (Start) begin
                        state_next_s = S_WAIT_START;
                    end else begin
                        state_next_s = S_IDLE;
                    end
                end
                S_WAIT_START: begin
                    cnt_next_s = {CNT_W{1'b0}};
                    if (!Rx_Bit) begin
                        state_next_s = S_START_CHK;
                    end else begin
                        state_next_s = S_WAIT_START;
                    end
                end
                S_START_CHK: begin
                    // Mid start bit: a 1 here means the falling edge was a glitch.
                    if (cnt_r == CNT_HALF) begin
                        cnt_next_s = {CNT_W{1'b0}};
                        idx_next_s = {IDX_W{1'b0}};
                        if (Rx_Bit) begin
                            state_next_s = S_WAIT_START;
                        end else begin
                            state_next_s = S_DATA;
                        end
                    end else begin
                        state_next_s = S_START_CHK;
                    end
                end
                S_DATA: begin
                    if (cnt_r == CNT_LAST) begin
                        cnt_next_s    = {CNT_W{1'b0}};
                        sample_data_s = 1'b1;
                        idx_next_s    = idx_r + IDX_W'(1);
                        if (idx_r == IDX_LAST) begin
`ifdef RX_PARITY_CHECK_EN
                            state_next_s = S_PARITY;
`else
                            state_next_s = S_STOP;
`endif
                        end else begin
                            state_next_s = S_DATA;
                        end
                    end else begin
                        state_next_s = S_DATA;
                    end
                end
`ifdef RX_PARITY_CHECK_EN
                S_PARITY: begin
                    if (cnt_r == CNT_LAST) begin
                        cnt_next_s   = {CNT_W{1'b0}};
                        sample_par_s = 1'b1;
                        state_next_s = S_STOP;
                    end else begin
                        state_next_s = S_PARITY;
                    end
                end
`endif
                S_STOP: begin
                    if (cnt_r == CNT_LAST) begin
                        cnt_next_s    = {CNT_W{1'b0}};
                        sample_stop_s = 1'b1;
                        state_next_s  = S_WAIT_START;
                    end else begin
                        state_next_s = S_STOP;
                    end
                end
                default: begin
                    state_next_s = S_IDLE;
                    cnt_next_s   = {CNT_W{1'b0}};
                    idx_next_s   = {IDX_W{1'b0}};
                end
            endcase
        end
    end

    // A word is committed only on a good stop bit (and good parity if enabled).
    always_comb begin
`ifdef RX_PARITY_CHECK_EN
        commit_s = sample_stop_s & Rx_Bit & ~par_bad_r;
`else
        commit_s = sample_stop_s & Rx_Bit;
`endif
        busy_next_s = (state_next_s == S_START_CHK) || (state_next_s == S_DATA) ||
                      (state_next_s == S_PARITY)    || (state_next_s == S_STOP);
    end

    // LSB-first deserializer: each new bit enters at the MSB end.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            shift_r <= {DATA_BITS{1'b0}};
        end else if (sample_data_s) begin
            shift_r <= {Rx_Bit, shift_r[DATA_BITS-1:1]};
        end else begin
            shift_r <= shift_r;
        end
    end

`ifdef RX_PARITY_CHECK_EN
    // Parity verdict, held until the stop bit of the same frame is sampled.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            par_bad_r  <= 1'b0;
            Parity_Err <= 1'b0;
        end else if (sample_par_s) begin
            par_bad_r  <= parity_odd(shift_r, Rx_Bit);
            Parity_Err <= parity_odd(shift_r, Rx_Bit);
        end else begin
            par_bad_r  <= par_bad_r;
            Parity_Err <= 1'b0;
        end
    end
`else
    // No parity stage in this build; the error output stays low.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            Parity_Err <= 1'b0;
        end else begin
            Parity_Err <= 1'b0;
        end
    end
`endif

    // Registered stage controls, status and error pulses, driven from the next state.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            Rx_Enable   <= 1'b0;
            Rx_Disable  <= 1'b1;
            Busy        <= 1'b0;
            Framing_Err <= 1'b0;
            Overrun     <= 1'b0;
        end else begin
            Rx_Enable   <= (state_next_s != S_IDLE);
            Rx_Disable  <= (state_next_s == S_IDLE);
            Busy        <= busy_next_s;
            Framing_Err <= sample_stop_s & ~Rx_Bit;
            Overrun     <= commit_s & frame.Frame_Valid & ~frame.Frame_Ready;
        end
    end

    // Output word holding register; a held word is never overwritten.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            frame.Frame_Data  <= {DATA_BITS{1'b0}};
            frame.Frame_Valid <= 1'b0;
        end else if (commit_s && (!frame.Frame_Valid || frame.Frame_Ready)) begin
            frame.Frame_Data  <= shift_r;
            frame.Frame_Valid <= 1'b1;
        end else if (frame.Frame_Valid && frame.Frame_Ready) begin
            frame.Frame_Data  <= frame.Frame_Data;
            frame.Frame_Valid <= 1'b0;
        end else begin
            frame.Frame_Data  <= frame.Frame_Data;
            frame.Frame_Valid <= frame.Frame_Valid;
        end
    end

endmodule
